// File: rtl/nand_io_pkg.sv
// Shared types and default ONFI mode-0 data-phase timing for the NAND IO units.
// Timing values are in clk cycles.
package nand_io_pkg;

   typedef enum logic {
      IO_READ  = 1'b0,
      IO_WRITE = 1'b1
   } io_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STROBE,
      HOLD
   } io_state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_LEN_W  = 12;
   localparam int DEF_T_WP   = 3;
   localparam int DEF_T_WH   = 2;
   localparam int DEF_T_REA  = 4;
   localparam int DEF_T_REH  = 2;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/nand_io_timer.sv
// Loadable down-counter pacing strobe phases; expire is high while the count sits at 1,
// so a phase loaded with N lasts exactly N cycles.
module nand_io_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expire = (count == W'(1));

endmodule

// File: rtl/nand_io_burst_unit.sv
// NAND data-phase engine: bursts of len+1 read or write beats, one WE#/RE# strobe per beat,
// with every output registered.
module nand_io_burst_unit
   import nand_io_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int T_WP   = DEF_T_WP,
   parameter int T_WH   = DEF_T_WH,
   parameter int T_REA  = DEF_T_REA,
   parameter int T_REH  = DEF_T_REH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              activate,
   input  logic              io_type,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              bus_oe,
   output logic              io_ctrl,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done
);

   localparam int DLY_W = $clog2(max_of4(T_WP, T_WH, T_REA, T_REH) + 1);
   localparam logic [DLY_W-1:0] WP_L  = DLY_W'(T_WP);
   localparam logic [DLY_W-1:0] WH_L  = DLY_W'(T_WH);
   localparam logic [DLY_W-1:0] REA_L = DLY_W'(T_REA);
   localparam logic [DLY_W-1:0] REH_L = DLY_W'(T_REH);

   io_state_t         state, state_nxt;
   io_t               type_q, type_nxt;
   logic [LEN_W-1:0]  beat_cnt, beat_nxt;
   logic [DATA_W-1:0] data_out_nxt, rd_data_nxt;
   logic              bus_oe_nxt, io_ctrl_nxt, rd_valid_nxt;
   logic              busy_nxt, done_nxt, wr_ready_nxt;
   logic              tmr_load, tmr_expire;
   logic [DLY_W-1:0]  tmr_val;

   nand_io_timer #(
      .W(DLY_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         type_q   <= IO_READ;
         beat_cnt <= '0;
         data_out <= '0;
         bus_oe   <= 1'b0;
         io_ctrl  <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         type_q   <= type_nxt;
         beat_cnt <= beat_nxt;
         data_out <= data_out_nxt;
         bus_oe   <= bus_oe_nxt;
         io_ctrl  <= io_ctrl_nxt;
         rd_data  <= rd_data_nxt;
         rd_valid <= rd_valid_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         wr_ready <= wr_ready_nxt;
      end
   end

   // beat_cnt is tested for zero before decrementing, so len of all ones runs 2^LEN_W beats
   always_comb begin
      state_nxt    = state;
      type_nxt     = type_q;
      beat_nxt     = beat_cnt;
      data_out_nxt = data_out;
      bus_oe_nxt   = bus_oe;
      io_ctrl_nxt  = io_ctrl;
      rd_data_nxt  = rd_data;
      rd_valid_nxt = 1'b0;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      wr_ready_nxt = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = '0;

      case (state)
         IDLE: begin
            io_ctrl_nxt = 1'b1;
            if (activate) begin
               type_nxt = io_t'(io_type);
               beat_nxt = len;
               busy_nxt = 1'b1;
               if (io_t'(io_type) == IO_WRITE) begin
                  state_nxt    = FETCH;
                  wr_ready_nxt = 1'b1;
               end else begin
                  state_nxt   = STROBE;
                  io_ctrl_nxt = 1'b0;
                  tmr_load    = 1'b1;
                  tmr_val     = REA_L;
               end
            end
         end

         FETCH: begin
            io_ctrl_nxt  = 1'b1;
            wr_ready_nxt = 1'b1;
            if (wr_valid && wr_ready) begin
               data_out_nxt = wr_data;
               bus_oe_nxt   = 1'b1;
               io_ctrl_nxt  = 1'b0;
               wr_ready_nxt = 1'b0;
               tmr_load     = 1'b1;
               tmr_val      = WP_L;
               state_nxt    = STROBE;
            end
         end

         STROBE: begin
            if (tmr_expire) begin
               io_ctrl_nxt = 1'b1;
               tmr_load    = 1'b1;
               state_nxt   = HOLD;
               if (type_q == IO_WRITE) begin
                  tmr_val = WH_L;
               end else begin
                  tmr_val      = REH_L;
                  rd_data_nxt  = data_in;
                  rd_valid_nxt = 1'b1;
               end
            end
         end

         HOLD: begin
            if (tmr_expire) begin
               if (beat_cnt != '0) begin
                  beat_nxt = beat_cnt - LEN_W'(1);
                  if (type_q == IO_WRITE) begin
                     state_nxt    = FETCH;
                     wr_ready_nxt = 1'b1;
                  end else begin
                     state_nxt   = STROBE;
                     io_ctrl_nxt = 1'b0;
                     tmr_load    = 1'b1;
                     tmr_val     = REA_L;
                  end
               end else begin
                  state_nxt    = IDLE;
                  done_nxt     = 1'b1;
                  busy_nxt     = 1'b0;
                  bus_oe_nxt   = 1'b0;
                  data_out_nxt = '0;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nand_io_burst_unit.sv
// Randomized directed bench for nand_io_burst_unit; a negedge monitor records strobe runs
// and beats, and each burst is scored against timing derived from the beat arithmetic.
module tb_nand_io_burst_unit;
   import nand_io_pkg::*;

   localparam int DW    = 16;
   localparam int LW    = 12;
   localparam int T_WP  = 3;
   localparam int T_WH  = 2;
   localparam int T_REA = 4;
   localparam int T_REH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          activate = 1'b0;
   logic          io_type = 1'b0;
   logic [LW-1:0] len = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] data_in;
   logic          wr_ready, bus_oe, io_ctrl, rd_valid, busy, done;
   logic [DW-1:0] data_out, rd_data;

   logic          s_activate = 1'b0;
   logic [3:0]    s_len = '0;
   logic [7:0]    s_data_in;
   logic          s_wr_ready, s_bus_oe, s_io_ctrl, s_rd_valid, s_busy, s_done;
   logic [7:0]    s_data_out, s_rd_data;

   always #5 clk = ~clk;

   nand_io_burst_unit #(
      .DATA_W(DW), .LEN_W(LW), .T_WP(T_WP), .T_WH(T_WH), .T_REA(T_REA), .T_REH(T_REH)
   ) dut (
      .clk(clk), .reset(reset), .activate(activate), .io_type(io_type), .len(len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .data_in(data_in),
      .data_out(data_out), .bus_oe(bus_oe), .io_ctrl(io_ctrl), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .done(done)
   );

   nand_io_burst_unit #(
      .DATA_W(8), .LEN_W(4), .T_WP(T_WP), .T_WH(T_WH), .T_REA(T_REA), .T_REH(T_REH)
   ) dut_small (
      .clk(clk), .reset(reset), .activate(s_activate), .io_type(1'b0), .len(s_len),
      .wr_data(8'h00), .wr_valid(1'b0), .wr_ready(s_wr_ready), .data_in(s_data_in),
      .data_out(s_data_out), .bus_oe(s_bus_oe), .io_ctrl(s_io_ctrl), .rd_data(s_rd_data),
      .rd_valid(s_rd_valid), .busy(s_busy), .done(s_done)
   );

   int n_chk = 0;
   int n_pass = 0;

   int            cyc = 0;
   int            low_run = 0;
   int            runs_q[$];
   int            low_start_q[$];
   logic [DW-1:0] wdat_q[$];
   logic          oe_q[$];
   logic [DW-1:0] hold_q[$];
   logic [DW-1:0] rdat_q[$];
   int            done_cyc_q[$];
   logic [DW-1:0] rd_src[$];
   int            rd_idx = 0;

   int            s_low_run = 0;
   int            s_runs = 0;
   int            s_done_cnt = 0;
   int            s_done_cyc = 0;
   int            s_src_n = 0;
   logic [7:0]    s_rdat_q[$];

   // Each cycle is labelled at its negedge; read data is only valid on the last RE# low cycle
   always @(negedge clk) begin
      cyc++;
      if (io_ctrl === 1'b0) begin
         low_run++;
         if (low_run == 1) begin
            low_start_q.push_back(cyc);
            wdat_q.push_back(data_out);
            oe_q.push_back(bus_oe);
         end
      end else if (low_run != 0) begin
         runs_q.push_back(low_run);
         hold_q.push_back(data_out);
         low_run = 0;
      end
      if (io_ctrl === 1'b0 && low_run == T_REA && rd_idx < rd_src.size()) begin
         data_in = rd_src[rd_idx];
         rd_idx++;
      end else begin
         data_in = DW'($urandom);
      end
      if (rd_valid === 1'b1) rdat_q.push_back(rd_data);
      if (done === 1'b1) done_cyc_q.push_back(cyc);

      if (s_io_ctrl === 1'b0) begin
         s_low_run++;
      end else if (s_low_run != 0) begin
         s_runs++;
         s_low_run = 0;
      end
      if (s_io_ctrl === 1'b0 && s_low_run == T_REA) begin
         s_data_in = 8'(s_src_n) ^ 8'hA5;
         s_src_n++;
      end else begin
         s_data_in = 8'($urandom);
      end
      if (s_rd_valid === 1'b1) s_rdat_q.push_back(s_rd_data);
      if (s_done === 1'b1) begin
         s_done_cnt++;
         s_done_cyc = cyc;
      end
   end

   int b_runs, b_lo, b_rd, b_done;

   task automatic mark();
      b_runs = runs_q.size();
      b_lo   = low_start_q.size();
      b_rd   = rdat_q.size();
      b_done = done_cyc_q.size();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_timeout", 64'(ok), 64'd1);
   endtask

   task automatic check_done_once(input int exp_cyc, input bit check_cyc);
      chk("done_count", 64'(done_cyc_q.size() - b_done), 64'd1);
      if (check_cyc)
         chk("done_cycle", (b_done < done_cyc_q.size()) ? 64'(done_cyc_q[b_done]) : 64'hFFFF,
             64'(exp_cyc));
   endtask

   task automatic write_burst(input int L, input int stall_beat, input int stall_n);
      logic [DW-1:0] d[$];
      int a;
      bit ok;
      mark();
      for (int b = 0; b <= L; b++) d.push_back(DW'($urandom));
      @(posedge clk); #1;
      activate = 1'b1; io_type = IO_WRITE; len = LW'(L);
      wr_valid = 1'b1; wr_data = d[0]; a = cyc + 1;
      @(posedge clk); #1;
      activate = 1'b0;
      for (int b = 0; b <= L; b++) begin
         if (b == stall_beat) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (wr_ready === 1'b1) begin ok = 1'b1; break; end
            end
            chk("stall_ready_timeout", 64'(ok), 64'd1);
            for (int i = 0; i < stall_n; i++) begin
               if (i > 0) @(negedge clk);
               chk("stall_strobe", 64'(io_ctrl), 64'd1);
               chk("stall_busy", 64'(busy), 64'd1);
               chk("stall_oe", 64'(bus_oe), 64'd1);
            end
            @(negedge clk);
            wr_data = d[b]; wr_valid = 1'b1;
         end else begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (wr_ready === 1'b1) begin ok = 1'b1; break; end
            end
            chk("wr_handshake_timeout", 64'(ok), 64'd1);
         end
         @(posedge clk); #1;
         if (b < L && b + 1 != stall_beat) wr_data = d[b + 1];
         else wr_valid = 1'b0;
      end
      wait_done(80, ok);
      repeat (3) @(negedge clk);
      #1;
      chk("wr_runs", 64'(runs_q.size() - b_runs), 64'(L + 1));
      for (int b = 0; b <= L; b++) begin
         int ir = b_runs + b;
         int il = b_lo + b;
         chk("wr_low_len", (ir < runs_q.size()) ? 64'(runs_q[ir]) : 64'hFFFF, 64'(T_WP));
         chk("wr_data_out", (il < wdat_q.size()) ? 64'(wdat_q[il]) : 64'hFFFFF, 64'(d[b]));
         chk("wr_bus_oe", (il < oe_q.size()) ? 64'(oe_q[il]) : 64'hF, 64'd1);
         chk("wr_hold_data", (ir < hold_q.size()) ? 64'(hold_q[ir]) : 64'hFFFFF, 64'(d[b]));
      end
      check_done_once(a + (L + 1) * (1 + T_WP + T_WH) + 1, stall_beat < 0);
      if (stall_beat < 0)
         chk("wr_first_low", (b_lo < low_start_q.size()) ? 64'(low_start_q[b_lo]) : 64'hFFFF,
             64'(a + 2));
      chk("wr_end_oe", 64'(bus_oe), 64'd0);
      chk("wr_end_data", 64'(data_out), 64'd0);
      chk("wr_end_busy", 64'(busy), 64'd0);
   endtask

   task automatic read_burst(input int L, input bit mid_act);
      logic [DW-1:0] e[$];
      int a;
      bit ok;
      mark();
      for (int b = 0; b <= L; b++) begin
         e.push_back(DW'($urandom));
         rd_src.push_back(e[b]);
      end
      @(posedge clk); #1;
      activate = 1'b1; io_type = IO_READ; len = LW'(L); a = cyc + 1;
      @(posedge clk); #1;
      activate = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (mid_act && i == 4) begin
            activate = 1'b1; io_type = IO_WRITE; len = LW'(7);
         end else begin
            activate = 1'b0;
         end
         if (i == 2) chk("rd_busy", 64'(busy), 64'd1);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
      chk("done_timeout", 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("rd_runs", 64'(runs_q.size() - b_runs), 64'(L + 1));
      chk("rd_beats", 64'(rdat_q.size() - b_rd), 64'(L + 1));
      for (int b = 0; b <= L; b++) begin
         int ir = b_runs + b;
         int id = b_rd + b;
         chk("rd_low_len", (ir < runs_q.size()) ? 64'(runs_q[ir]) : 64'hFFFF, 64'(T_REA));
         chk("rd_data", (id < rdat_q.size()) ? 64'(rdat_q[id]) : 64'hFFFFF, 64'(e[b]));
      end
      chk("rd_first_low", (b_lo < low_start_q.size()) ? 64'(low_start_q[b_lo]) : 64'hFFFF,
          64'(a + 1));
      check_done_once(a + (L + 1) * (T_REA + T_REH) + 1, 1'b1);
      chk("rd_end_busy", 64'(busy), 64'd0);
      chk("rd_end_oe", 64'(bus_oe), 64'd0);
   endtask

   initial begin
      bit ok;
      int d1, nlow, sa;
      logic prev;

      repeat (3) @(negedge clk);
      chk("rst_io_ctrl", 64'(io_ctrl), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_bus_oe", 64'(bus_oe), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_data_out", 64'(data_out), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("[TB] single-beat write");
      write_burst(0, -1, 0);
      $display("[TB] four-beat read");
      read_burst(3, 1'b0);
      $display("[TB] write with stalled beat 2");
      write_burst(2, 2, 5);
      $display("[TB] read with activate pulsed mid-burst");
      read_burst(2, 1'b1);

      $display("[TB] activate on the done cycle starts a fresh burst");
      mark();
      for (int b = 0; b < 4; b++) rd_src.push_back(DW'($urandom));
      @(posedge clk); #1;
      activate = 1'b1; io_type = IO_READ; len = LW'(1);
      @(posedge clk); #1;
      activate = 1'b0;
      wait_done(100, ok);
      activate = 1'b1; io_type = IO_READ; len = LW'(1);
      @(posedge clk); #1;
      activate = 1'b0;
      d1 = (b_done < done_cyc_q.size()) ? done_cyc_q[b_done] : 0;
      wait_done(100, ok);
      repeat (3) @(negedge clk);
      #1;
      chk("chain_runs", 64'(runs_q.size() - b_runs), 64'd4);
      chk("chain_beats", 64'(rdat_q.size() - b_rd), 64'd4);
      chk("chain_done_count", 64'(done_cyc_q.size() - b_done), 64'd2);
      chk("chain_first_low2", (b_lo + 2 < low_start_q.size()) ? 64'(low_start_q[b_lo + 2]) : 64'hFFFF,
          64'(d1 + 1));
      chk("chain_done2", (b_done + 1 < done_cyc_q.size()) ? 64'(done_cyc_q[b_done + 1]) : 64'hFFFF,
          64'(d1 + 2 * (T_REA + T_REH) + 1));
      for (int b = 0; b < 4; b++)
         chk("chain_rd_data", (b_rd + b < rdat_q.size()) ? 64'(rdat_q[b_rd + b]) : 64'hFFFFF,
             64'(rd_src[rd_src.size() - 4 + b]));

      $display("[TB] reset during the strobe of beat 1");
      mark();
      @(posedge clk); #1;
      activate = 1'b1; io_type = IO_WRITE; len = LW'(3); wr_valid = 1'b1; wr_data = 16'h1234;
      @(posedge clk); #1;
      activate = 1'b0;
      nlow = 0; prev = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (io_ctrl === 1'b0 && prev === 1'b1) nlow++;
         prev = io_ctrl;
         if (nlow == 2) break;
      end
      chk("rst_mid_reach_beat1", 64'(nlow), 64'd2);
      reset = 1'b1; wr_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_io_ctrl", 64'(io_ctrl), 64'd1);
      chk("rst_mid_bus_oe", 64'(bus_oe), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("rst_mid_no_done", 64'(done_cyc_q.size() - b_done), 64'd0);
      chk("rst_mid_idle_strobe", 64'(io_ctrl), 64'd1);
      write_burst(2, -1, 0);

      $display("[TB] random bursts");
      repeat (4) begin
         if ($urandom_range(0, 1) == 1) read_burst(int'($urandom_range(0, 4)), 1'b0);
         else write_burst(int'($urandom_range(0, 4)), -1, 0);
      end

      $display("[TB] narrow unit, len all ones");
      @(posedge clk); #1;
      s_activate = 1'b1; s_len = 4'hF; sa = cyc + 1;
      @(posedge clk); #1;
      s_activate = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (s_done === 1'b1) begin ok = 1'b1; break; end
      end
      chk("small_done_timeout", 64'(ok), 64'd1);
      repeat (30) @(negedge clk);
      #1;
      chk("small_beats", 64'(s_runs), 64'd16);
      chk("small_rd_count", 64'(s_rdat_q.size()), 64'd16);
      chk("small_done_count", 64'(s_done_cnt), 64'd1);
      chk("small_done_cycle", 64'(s_done_cyc), 64'(sa + 16 * (T_REA + T_REH) + 1));
      chk("small_rd_first", (s_rdat_q.size() > 0) ? 64'(s_rdat_q[0]) : 64'hFFF, 64'h0A5);
      chk("small_rd_last", (s_rdat_q.size() > 15) ? 64'(s_rdat_q[15]) : 64'hFFF, 64'(8'h0F ^ 8'hA5));
      chk("small_idle_busy", 64'(s_busy), 64'd0);
      chk("small_idle_oe", 64'(s_bus_oe), 64'd0);
      chk("small_idle_ready", 64'(s_wr_ready), 64'd0);
      chk("small_idle_data", 64'(s_data_out), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
